mmio_port_bank: RTL and testbench
=================================

Name: mmio_port_bank

Overview:
- Parametrised memory-mapped GPIO bank; successor to the core's fixed eight 32-bit in/out ports.
- Adds per-port direction registers, byte-enabled writes, built-in input synchronisers, sticky change-detect flags and a combined interrupt line.
- Sits on the MemoryController's IO path: it decodes its own address window and returns read data with one cycle of latency.

Parameters:
NUM_PORTS, 8, number of 32-bit ports (1..16)
BASE_ADDR, 32'hFFFFFF00, byte address of port 0 register block; must be aligned to NUM_PORTS*16
SYNC_STAGES, 2, input synchroniser depth (2..4)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
address  input  32  byte address of access
writeData  input  32  write data; bit i maps to port bit i; byteEnable[0] selects bits 7:0
byteEnable  input  4  per-byte write enable
writeEnable  input  1  write strobe
readEnable  input  1  read strobe
readData  output  32  registered read data
readValid  output  1  one-cycle pulse: readData valid
addressMatch  output  1  combinational: address within window
badAccess  output  1  one-cycle pulse: matched but misaligned access
portInput  input  NUM_PORTS*32  external inputs; port p at bits [32p+31:32p]
portOutput  output  NUM_PORTS*32  output registers
portDirection  output  NUM_PORTS*32  direction registers; 1 = drive
interruptPending  output  1  OR of all change flags on input-direction bits

Behaviour:
- Register map, per port p at BASE_ADDR + 16p:
  - +0 OUT: read/write.
  - +4 DIR: read/write.
  - +8 IN: read-only, synchronised value; writes are ignored.
  - +C CHG: sticky change flags, write-1-to-clear.
- Window: addressMatch = (address >= BASE_ADDR) && (address < BASE_ADDR + NUM_PORTS*16).
- Accesses are word-aligned only. Matched access with address[1:0] != 0:
  - no register change;
  - badAccess pulses the next cycle;
  - a read still gives a readValid pulse with readData = 0.
- Unmatched accesses are ignored entirely: no readValid, no badAccess.
- Writes take effect at the clock edge. Only bytes with byteEnable set are updated; CHG clears only enabled bytes' 1-bits.
- Reads: readEnable with a match registers readData and pulses readValid the next cycle. readData holds its value until the next valid read.
- Same-cycle read and write to the same register: the write commits and the read returns the pre-write value.
- Synchroniser: SYNC_STAGES flops per input bit; syncIn = last stage. prevIn register captures syncIn every cycle.
- Change detect:
  - changeBits = syncIn ^ prevIn; CHG |= changeBits every cycle once primed.
  - Set wins over a same-cycle W1C clear on the same bit.
- Priming: a counter holds detection off for SYNC_STAGES+1 cycles after reset release, so static inputs are never flagged. The counter saturates and has no further effect.
- interruptPending = |(CHG & ~DIR) over all ports. It is registered: asserted the cycle after the flag sets.
- Reset (asynchronous assert, reset = 0); all outputs are valid during reset:
  - OUT, DIR, CHG, sync flops, prevIn, readData and the priming counter clear to 0.
  - readValid, badAccess and interruptPending are 0.
- Reset mid-access: the pending read is discarded and readValid stays 0.
- Flags from bits with DIR = 1 are still recorded in CHG but are masked from interruptPending.

Test Plan:
1. Reset with portInput port0 = 32'hFFFF0000, wait 10 cycles, read FFFFFF0C -> readValid the next cycle, readData = 0 (priming suppresses the flag), interruptPending = 0.
2. Write FFFFFF10 data 32'hA5A5A5A5 with byteEnable = 4'b0101 -> portOutput[63:32] = 32'h00A500A5; readback returns the same value.
3. Toggle port2 input bit 3 0->1 -> CHG2 bit 3 sets exactly SYNC_STAGES+1 cycles later and interruptPending asserts one cycle after that. Write 32'h8 to FFFFFF2C -> flag clears and interruptPending drops the next cycle.
4. Set DIR3 = 32'hFFFFFFFF, toggle port3 input bit 0 -> CHG3 = 1, interruptPending stays 0.
5. Edge coincident with a W1C write to the same bit -> flag remains 1. Simultaneous read and write to OUT0 of 32'h1234 over old value 0 -> readData = 0, OUT0 = 32'h1234.
6. Read FFFFFF02 -> badAccess pulses, readData = 0. Read 32'h00000100 -> no readValid, addressMatch = 0. Assert reset during a read -> readValid stays 0 and all outputs clear.

Source files
------------

// File: rtl/mmio_port_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_port_bank
// Purpose  : Memory-mapped GPIO bank with direction, sync, change flags, IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_port_bank #(
   parameter int          NUM_PORTS   = 8,
   parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF00,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [31:0]             address,
   input  logic [31:0]             writeData,
   input  logic [3:0]              byteEnable,
   input  logic                    writeEnable,
   input  logic                    readEnable,
   output logic [31:0]             readData,
   output logic                    readValid,
   output logic                    addressMatch,
   output logic                    badAccess,
   input  logic [NUM_PORTS*32-1:0] portInput,
   output logic [NUM_PORTS*32-1:0] portOutput,
   output logic [NUM_PORTS*32-1:0] portDirection,
   output logic                    interruptPending
);

   localparam int          c_IDX_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int          c_W            = NUM_PORTS * 32;
   localparam logic [32:0] c_WIN_END      = {1'b0, BASE_ADDR} + 33'(NUM_PORTS * 16);
   localparam logic [2:0]  c_PRIME_CYCLES = 3'(SYNC_STAGES + 1);

   localparam logic [1:0]  c_SEL_OUT = 2'd0;
   localparam logic [1:0]  c_SEL_DIR = 2'd1;
   localparam logic [1:0]  c_SEL_IN  = 2'd2;
   localparam logic [1:0]  c_SEL_CHG = 2'd3;

   logic [c_W-1:0]                  r_out;
   logic [c_W-1:0]                  r_dir;
   logic [c_W-1:0]                  r_chg;
   logic [c_W-1:0]                  r_prevIn;
   logic [SYNC_STAGES-1:0][c_W-1:0] r_sync;
   logic [2:0]                      r_primeCnt;
   logic [31:0]                     r_readData;
   logic                            r_readValid;
   logic                            r_badAccess;
   logic                            r_irq;

   logic                 w_match;
   logic                 w_aligned;
   logic                 w_wrOk;
   logic                 w_rdOk;
   logic                 w_primed;
   logic [c_IDX_W-1:0]   w_idx;
   logic [1:0]           w_sel;
   logic [c_IDX_W+4:0]   w_base;
   logic [31:0]          w_byteMask;
   logic [31:0]          w_rdWord;
   logic [c_W-1:0]       w_syncIn;
   logic [c_W-1:0]       w_change;
   logic [c_W-1:0]       w_set;
   logic [c_W-1:0]       w_clear;

   // Widened compare so a window ending at the top of the address space never wraps.
   assign w_match   = ({1'b0, address} >= {1'b0, BASE_ADDR}) && ({1'b0, address} < c_WIN_END);
   assign w_aligned = (address[1:0] == 2'b00);
   // Base is aligned to the window size, so port index is a narrow subtraction.
   assign w_idx     = address[c_IDX_W+3:4] - BASE_ADDR[c_IDX_W+3:4];
   assign w_sel     = address[3:2];
   assign w_base    = {w_idx, 5'b00000};
   assign w_wrOk    = writeEnable && w_match && w_aligned;
   assign w_rdOk    = readEnable && w_match;

   assign w_byteMask = {{8{byteEnable[3]}}, {8{byteEnable[2]}},
                        {8{byteEnable[1]}}, {8{byteEnable[0]}}};

   assign w_syncIn = r_sync[SYNC_STAGES-1];
   assign w_change = w_syncIn ^ r_prevIn;
   assign w_primed = (r_primeCnt == c_PRIME_CYCLES);
   assign w_set    = w_primed ? w_change : '0;

   always_comb begin
      w_clear = '0;
      if (w_wrOk && (w_sel == c_SEL_CHG)) begin
         w_clear[w_base +: 32] = writeData & w_byteMask;
      end
   end

   always_comb begin
      w_rdWord = '0;
      case (w_sel)
         c_SEL_OUT: w_rdWord = r_out[w_base +: 32];
         c_SEL_DIR: w_rdWord = r_dir[w_base +: 32];
         c_SEL_IN:  w_rdWord = w_syncIn[w_base +: 32];
         c_SEL_CHG: w_rdWord = r_chg[w_base +: 32];
         default:   w_rdWord = '0;
      endcase
   end

   // Input synchroniser, edge history and the post-reset priming counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync     <= '0;
         r_prevIn   <= '0;
         r_primeCnt <= '0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], portInput};
         r_prevIn   <= w_syncIn;
         if (!w_primed) begin
            r_primeCnt <= r_primeCnt + 3'd1;
         end
      end
   end

   // Register file; a set in the same cycle as a W1C on the same bit wins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_out <= '0;
         r_dir <= '0;
         r_chg <= '0;
      end else begin
         r_chg <= (r_chg & ~w_clear) | w_set;
         if (w_wrOk && (w_sel == c_SEL_OUT)) begin
            r_out[w_base +: 32] <= (r_out[w_base +: 32] & ~w_byteMask) | (writeData & w_byteMask);
         end
         if (w_wrOk && (w_sel == c_SEL_DIR)) begin
            r_dir[w_base +: 32] <= (r_dir[w_base +: 32] & ~w_byteMask) | (writeData & w_byteMask);
         end
      end
   end

   // Bus response path: reads see pre-write register contents.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_readData  <= '0;
         r_readValid <= 1'b0;
         r_badAccess <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_readValid <= w_rdOk;
         if (w_rdOk) begin
            r_readData <= w_aligned ? w_rdWord : 32'd0;
         end
         r_badAccess <= w_match && (readEnable || writeEnable) && !w_aligned;
         r_irq       <= |(r_chg & ~r_dir);
      end
   end

   assign readData         = r_readData;
   assign readValid        = r_readValid;
   assign badAccess        = r_badAccess;
   assign addressMatch     = w_match;
   assign portOutput       = r_out;
   assign portDirection    = r_dir;
   assign interruptPending = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_port_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mmio_port_bank
// Purpose  : Scoreboard bench with a rule-level model of the GPIO bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_port_bank;

   localparam int          NUM_PORTS   = 8;
   localparam logic [31:0] BASE_ADDR   = 32'hFFFFFF00;
   localparam int          SYNC_STAGES = 2;
   localparam int          W           = NUM_PORTS * 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   address = '0;
   logic [31:0]   writeData = '0;
   logic [3:0]    byteEnable = '0;
   logic          writeEnable = 1'b0;
   logic          readEnable = 1'b0;
   logic [31:0]   readData;
   logic          readValid;
   logic          addressMatch;
   logic          badAccess;
   logic [W-1:0]  portInput = '0;
   logic [W-1:0]  portOutput;
   logic [W-1:0]  portDirection;
   logic          interruptPending;

   mmio_port_bank #(
      .NUM_PORTS(NUM_PORTS), .BASE_ADDR(BASE_ADDR), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clock(clock), .reset(reset), .address(address), .writeData(writeData),
      .byteEnable(byteEnable), .writeEnable(writeEnable), .readEnable(readEnable),
      .readData(readData), .readValid(readValid), .addressMatch(addressMatch),
      .badAccess(badAccess), .portInput(portInput), .portOutput(portOutput),
      .portDirection(portDirection), .interruptPending(interruptPending)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        isRead;
      logic        bad;
      logic [31:0] data;
   } resp_t;

   logic [31:0]  mOut [NUM_PORTS];
   logic [31:0]  mDir [NUM_PORTS];
   logic [31:0]  mChg [NUM_PORTS];
   logic         mIrq;
   logic [W-1:0] hist [$];   // hist[k] = input value sampled k+1 edges ago
   int           edges;
   resp_t        sb [$];
   int           vectors = 0;
   int           miscompares = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic bit inWindow(logic [31:0] a);
      return (64'(a) >= 64'(BASE_ADDR)) && (64'(a) < 64'(BASE_ADDR) + 64'(NUM_PORTS * 16));
   endfunction

   function automatic void model_reset();
      for (int p = 0; p < NUM_PORTS; p++) begin
         mOut[p] = '0; mDir[p] = '0; mChg[p] = '0;
      end
      mIrq = 1'b0;
      hist.delete();
      for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back('0);
      edges = 0;
      sb.delete();
   endfunction

   // Applies one rising edge worth of behaviour using the inputs present at that edge.
   function automatic void model_edge();
      logic [W-1:0] syncNow = hist[SYNC_STAGES-1];
      logic [W-1:0] prevNow = hist[SYNC_STAGES];
      logic [W-1:0] change  = syncNow ^ prevNow;
      logic [31:0]  off     = address - BASE_ADDR;
      int           p       = int'(off >> 4);
      int           r       = int'(off[3:2]);
      bit           match   = inWindow(address);
      bit           aligned = (address[1:0] == 2'b00);
      logic [31:0]  mask    = {{8{byteEnable[3]}}, {8{byteEnable[2]}}, {8{byteEnable[1]}}, {8{byteEnable[0]}}};
      logic [31:0]  rd      = '0;
      logic [31:0]  clr [NUM_PORTS];
      bit           irq     = 1'b0;
      resp_t        item;

      for (int q = 0; q < NUM_PORTS; q++) begin
         clr[q] = '0;
         irq = irq | (|(mChg[q] & ~mDir[q]));
      end

      if (match) begin
         case (r)
            0: rd = mOut[p];
            1: rd = mDir[p];
            2: rd = syncNow[p*32 +: 32];
            default: rd = mChg[p];
         endcase
         if (readEnable || (writeEnable && !aligned)) begin
            item.isRead = readEnable;
            item.bad    = !aligned;
            item.data   = (readEnable && aligned) ? rd : 32'd0;
            sb.push_back(item);
         end
         if (writeEnable && aligned) begin
            if (r == 0) mOut[p] = (mOut[p] & ~mask) | (writeData & mask);
            if (r == 1) mDir[p] = (mDir[p] & ~mask) | (writeData & mask);
            if (r == 3) clr[p] = writeData & mask;
         end
      end

      for (int q = 0; q < NUM_PORTS; q++) begin
         mChg[q] = mChg[q] & ~clr[q];
         if (edges >= SYNC_STAGES + 1) mChg[q] = mChg[q] | change[q*32 +: 32];
      end
      mIrq = irq;
      edges++;
      hist.push_front(portInput);
      void'(hist.pop_back());
   endfunction

   // Monitor: compares DUT outputs against the model on every falling edge.
   always @(negedge clock) begin
      resp_t got;
      check("addressMatch", {31'd0, addressMatch}, {31'd0, inWindow(address)});
      if (readValid || badAccess) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpectedResponse: got readValid=%b badAccess=%b, required none", readValid, badAccess);
         end else begin
            got = sb.pop_front();
            check("readValid", {31'd0, readValid}, {31'd0, got.isRead});
            check("badAccess", {31'd0, badAccess}, {31'd0, got.bad});
            if (got.isRead) check("readData", readData, got.data);
         end
      end else if (sb.size() != 0) begin
         got = sb.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missingResponse: got none, required readValid=%b badAccess=%b data=%h",
                  got.isRead, got.bad, got.data);
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         check($sformatf("portOutput[%0d]", p), portOutput[p*32 +: 32], mOut[p]);
         check($sformatf("portDirection[%0d]", p), portDirection[p*32 +: 32], mDir[p]);
      end
      check("interruptPending", {31'd0, interruptPending}, {31'd0, mIrq});
   end

   task automatic tick();
      @(posedge clock);
      if (reset) model_edge();
      @(negedge clock);
      #1;
   endtask

   task automatic access(logic [31:0] a, logic we, logic re, logic [31:0] d, logic [3:0] be);
      address = a; writeEnable = we; readEnable = re; writeData = d; byteEnable = be;
      tick();
      writeEnable = 1'b0; readEnable = 1'b0;
   endtask

   initial begin
      int p, r, kind, b;
      logic [31:0] a;

      model_reset();
      portInput[31:0] = 32'hFFFF0000;
      #1 reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      #1 reset = 1'b1;
      repeat (10) tick();

      // Static input after reset is never flagged.
      access(BASE_ADDR + 32'h0C, 1'b0, 1'b1, '0, 4'h0);
      check("t1ReadValid", {31'd0, readValid}, 32'd1);
      check("t1ReadData", readData, 32'd0);
      check("t1Irq", {31'd0, interruptPending}, 32'd0);

      // Byte-enabled write.
      access(BASE_ADDR + 32'h10, 1'b1, 1'b0, 32'hA5A5A5A5, 4'b0101);
      check("t2Out1", portOutput[63:32], 32'h00A500A5);
      access(BASE_ADDR + 32'h10, 1'b0, 1'b1, '0, 4'h0);
      check("t2Readback", readData, 32'h00A500A5);

      // Change detect latency and W1C.
      portInput[64+3] = 1'b1;
      tick(); tick();
      access(BASE_ADDR + 32'h2C, 1'b0, 1'b1, '0, 4'h0);
      check("t3ChgBeforeSet", readData, 32'd0);
      check("t3IrqBeforeSet", {31'd0, interruptPending}, 32'd0);
      access(BASE_ADDR + 32'h2C, 1'b0, 1'b1, '0, 4'h0);
      check("t3ChgSet", readData, 32'h8);
      check("t3IrqSet", {31'd0, interruptPending}, 32'd1);
      access(BASE_ADDR + 32'h2C, 1'b1, 1'b0, 32'h8, 4'hF);
      check("t3IrqHeld", {31'd0, interruptPending}, 32'd1);
      tick();
      check("t3IrqDropped", {31'd0, interruptPending}, 32'd0);

      // Output-direction bits flag but do not interrupt.
      access(BASE_ADDR + 32'h34, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF);
      portInput[96] = 1'b1;
      repeat (3) tick();
      access(BASE_ADDR + 32'h3C, 1'b0, 1'b1, '0, 4'h0);
      check("t4Chg3", readData, 32'h1);
      check("t4IrqMasked", {31'd0, interruptPending}, 32'd0);

      // Set coincident with W1C keeps the flag.
      portInput[32+5] = 1'b1;
      tick(); tick();
      access(BASE_ADDR + 32'h1C, 1'b1, 1'b0, 32'h20, 4'b0001);
      access(BASE_ADDR + 32'h1C, 1'b0, 1'b1, '0, 4'h0);
      check("t5SetWins", readData, 32'h20);
      access(BASE_ADDR + 32'h1C, 1'b1, 1'b0, 32'h20, 4'b0001);
      access(BASE_ADDR + 32'h00, 1'b1, 1'b1, 32'h1234, 4'hF);
      check("t5ReadOld", readData, 32'd0);
      check("t5Out0", portOutput[31:0], 32'h1234);

      // Misaligned and out-of-window accesses.
      access(BASE_ADDR + 32'h02, 1'b0, 1'b1, '0, 4'h0);
      check("t6BadAccess", {31'd0, badAccess}, 32'd1);
      check("t6BadReadValid", {31'd0, readValid}, 32'd1);
      check("t6BadReadData", readData, 32'd0);
      address = 32'h00000100; readEnable = 1'b1;
      #1 check("t6NoMatch", {31'd0, addressMatch}, 32'd0);
      tick();
      readEnable = 1'b0;
      check("t6NoReadValid", {31'd0, readValid}, 32'd0);
      check("t6NoBad", {31'd0, badAccess}, 32'd0);

      // Reset arriving while a read is in flight.
      address = BASE_ADDR; readEnable = 1'b1;
      @(posedge clock);
      model_edge();
      #2 reset = 1'b0;
      model_reset();
      readEnable = 1'b0;
      @(negedge clock);
      #1;
      check("t6RstReadValid", {31'd0, readValid}, 32'd0);
      check("t6RstReadData", readData, 32'd0);
      check("t6RstOut0", portOutput[31:0], 32'd0);
      check("t6RstIrq", {31'd0, interruptPending}, 32'd0);
      reset = 1'b1;

      // Randomised traffic, including window edges and input toggles.
      for (int n = 0; n < 4000; n++) begin
         kind = $urandom_range(0, 11);
         p    = $urandom_range(0, NUM_PORTS - 1);
         r    = $urandom_range(0, 3);
         a    = BASE_ADDR + 32'(p * 16 + r * 4);
         if (kind == 0)      a = a + 32'($urandom_range(1, 3));
         else if (kind == 1) a = $urandom;
         else if (kind == 2) a = BASE_ADDR - 32'd4;
         else if (kind == 3) a = BASE_ADDR + 32'(NUM_PORTS * 16);
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, W - 1);
            portInput[b] = ~portInput[b];
         end
         access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      end

      tick(); tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboardDrain: got %0d outstanding, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
